serial_deframer: RTL and testbench

//  - Serial-to-parallel front end for the WIDTH-bit parallel register stage: receives framed serial bits, one per clk.
//  - Frame: start(0), WIDTH data bits LSB first, [parity], stop(1).
//  - Presents the assembled word on dout with a one-cycle dout_valid pulse; the downstream register captures dout on that pulse.

---
 rtl/serial_deframer_pkg.sv | 14 +
 rtl/sipo_shift.sv | 23 ++
 rtl/serial_deframer.sv | 131 +++++++++++++
 tb/tb_serial_deframer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_deframer_pkg.sv
// Shared definitions for serial_deframer: FSM state encodings and line levels.
package serial_deframer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register; new bits enter at the MSB and move toward bit 0.
module sipo_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// Framed serial receiver: start(0), WIDTH data bits LSB first, optional even parity, stop(1).
// Define DEFRAMER_PARITY_EN to build the parity stage; otherwise par_err is constant 0.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             par_err,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              par_err_q, par_err_d;
  logic              shift_en, clear;
  logic              par_bad;

  sipo_shift #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .shift_en(shift_en),
    .din     (din),
    .q       (shift_q)
  );

`ifdef DEFRAMER_PARITY_EN
  logic par_bad_q;

  // Even parity: data XOR parity bit must be 0; result is held for the stop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q <= 1'b0;
    end else if (state_q == StParity) begin
      par_bad_q <= (^shift_q) ^ din;
    end
  end

  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    par_err_d    = 1'b0;
    shift_en     = 1'b0;
    clear        = 1'b0;
    case (state_q)
      StIdle: begin
        if (din == StartBit) begin
          state_d = StData;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      StData: begin
        shift_en = 1'b1;
        if (cnt_q == CntMax) begin
          cnt_d = '0;
`ifdef DEFRAMER_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        state_d = StStop;
      end
      StStop: begin
        state_d     = StIdle;
        frame_err_d = (din != StopBit);
        par_err_d   = par_bad;
        if ((din == StopBit) && !par_bad) begin
          dout_d       = shift_q;
          dout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      par_err_q    <= par_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign par_err    = par_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: directed cases plus random framed traffic.
module tb_serial_deframer;

  localparam int unsigned WIDTH = 4;
`ifdef DEFRAMER_PARITY_EN
  localparam bit          ParEn    = 1'b1;
  localparam int unsigned FrameLen = WIDTH + 3;
`else
  localparam bit          ParEn    = 1'b0;
  localparam int unsigned FrameLen = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b1;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, frame_err, par_err, busy;

  int               n_cmp = 0;
  int               n_err = 0;
  int               cycle = 0;
  int               last_valid = -1000;
  logic [WIDTH-1:0] exp_dout = '0;

  always #5 clk = ~clk;

  serial_deframer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .frame_err (frame_err),
    .par_err   (par_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit at the falling edge; return 1 time unit after the sampling edge.
  task automatic step(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic quiet(input string tag);
    chk({tag, ".valid"}, dout_valid, 1'b0);
    chk({tag, ".ferr"}, frame_err, 1'b0);
    chk({tag, ".perr"}, par_err, 1'b0);
    chk({tag, ".dout"}, dout, exp_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      quiet("idle");
      chk("idle.busy", busy, 1'b0);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".dout"}, dout, '0);
    chk({tag, ".valid"}, dout_valid, 1'b0);
    chk({tag, ".ferr"}, frame_err, 1'b0);
    chk({tag, ".perr"}, par_err, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  // Sends one whole frame and checks every cycle; outcome judged from the frame contents alone.
  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop, input logic pflip,
                            input bit chk_gap);
    logic good;
    step(1'b0);
    quiet("start");
    chk("start.busy", busy, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      step(data[i]);
      quiet("data");
      chk("data.busy", busy, 1'b1);
    end
    if (ParEn) begin
      step((^data) ^ pflip);
      quiet("par");
      chk("par.busy", busy, 1'b1);
    end
    step(stop);
    good = stop && !(ParEn && pflip);
    if (good) exp_dout = data;
    chk("stop.valid", dout_valid, good);
    chk("stop.ferr", frame_err, !stop);
    chk("stop.perr", par_err, ParEn && pflip);
    chk("stop.dout", dout, exp_dout);
    chk("stop.busy", busy, 1'b0);
    if (good) begin
      if (chk_gap) chk("b2b.gap", cycle - last_valid, FrameLen);
      last_valid = cycle;
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    all_zero(tag);
    @(posedge clk);
    #1;
    all_zero({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    exp_dout = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             s, p;
    int               gap;

    // Power-on reset
    #1;
    rst = 1'b1;
    #1;
    all_zero("por");
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Directed good frame: din 0,0,1,1,1,1
    send_frame(4'b1110, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Back-to-back frames with no idle gap
    send_frame(4'b1111, 1'b1, 1'b0, 1'b0);
    send_frame(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Frame error keeps the previous word
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Parity pass then parity failure on the same data
    if (ParEn) begin
      send_frame(4'b0111, 1'b1, 1'b0, 1'b0);
      send_frame(4'b0111, 1'b1, 1'b1, 1'b0);
      send_frame(4'b1100, 1'b0, 1'b1, 1'b0);
      idle(1);
    end

    // Abort after two data bits, then a clean frame
    send_frame(4'b1001, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    async_reset("abort");
    idle(3);
    send_frame(4'b0101, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Random traffic, including zero-gap sequences
    for (int k = 0; k < 60; k++) begin
      d   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      s   = ($urandom_range(0, 4) != 0);
      p   = ParEn ? ($urandom_range(0, 4) == 0) : 1'b0;
      gap = $urandom_range(0, 2);
      send_frame(d, s, p, 1'b0);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
